// File: rtl/rgb_frame_receiver_pkg.sv
// Shared types for the raster-stream receiver: FSM states, pixel channel,
// configuration channel and per-frame statistics.
package rgb_frame_receiver_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    IDLE  = 2'd1,
    FRAME = 2'd2,
    DONE  = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_channel;

  typedef struct packed {
    logic [11:0] image_width;
    logic [11:0] lval_lines;
    logic [15:0] number_frames;
  } cof_channel;

  typedef struct packed {
    logic [11:0] width;
    logic [11:0] lines;
    logic [15:0] frame_cnt;
    logic        line_err;
    logic        frame_err;
  } frame_stats;

  // Red in the top byte, blue in the bottom byte.
  function automatic rgb_channel split_rgb(input logic valid, input logic [23:0] rgb);
    rgb_channel ch;
    ch.valid = valid;
    ch.red   = rgb[23:16];
    ch.green = rgb[15:8];
    ch.blue  = rgb[7:0];
    return ch;
  endfunction

endpackage

// File: rtl/rgb_frame_receiver_sync_edge_detect.sv
// Registers a strobe and flags its rising/falling transitions between the
// registered sample and the one before it.
module sync_edge_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic q_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      q      <= RESET_VAL;
      q_prev <= RESET_VAL;
    end else begin
      q      <= d;
      q_prev <= q;
    end
  end

  assign rise = q & ~q_prev;
  assign fall = ~q & q_prev;

endmodule

// File: rtl/rgb_frame_receiver.sv
// Raster-stream ingress: recovers x/y, sof/eof, checks line/frame geometry
// against configuration and stops after a configured number of frames.
module rgb_frame_receiver
  import rgb_frame_receiver_pkg::*;
#(
  parameter int DATA_WIDTH      = 24,
  parameter int COORD_WIDTH     = 12,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clkmm,
  input  logic                       reset,
  input  logic                       iFvalid,
  input  logic                       iLvalid,
  input  logic                       iValid,
  input  logic [DATA_WIDTH-1:0]      iRgb,
  input  logic [COORD_WIDTH-1:0]     iImageWidth,
  input  logic [COORD_WIDTH-1:0]     iLvalLines,
  input  logic [FRAME_CNT_WIDTH-1:0] iNumberFrames,
  input  logic                       iErrClear,
  output logic                       oValid,
  output logic [7:0]                 oRed,
  output logic [7:0]                 oGreen,
  output logic [7:0]                 oBlue,
  output logic [COORD_WIDTH-1:0]     oX,
  output logic [COORD_WIDTH-1:0]     oY,
  output logic                       oSof,
  output logic                       oEof,
  output logic [COORD_WIDTH-1:0]     oWidth,
  output logic [COORD_WIDTH-1:0]     oLines,
  output logic [FRAME_CNT_WIDTH-1:0] oFrameCnt,
  output logic                       oLineErr,
  output logic                       oFrameErr,
  output logic                       oDone
);

  function automatic logic [COORD_WIDTH-1:0] sat_inc(input logic [COORD_WIDTH-1:0] v);
    return (&v) ? v : v + COORD_WIDTH'(1);
  endfunction

  rx_state_t state, state_next;

  logic                  fval_p0, fval_rise, fval_fall;
  logic                  lval_p0, lval_rise, lval_fall;
  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] rgb_p0;

  logic                       start, active, pix, close_line, frame_close, limit;
  logic [COORD_WIDTH-1:0]     x, y, x_cur, y_cur, y_closed;
  logic                       sof_pending, sofp_cur;
  logic [FRAME_CNT_WIDTH-1:0] cnt_next;

  rgb_channel                 pix_p1;
  logic [COORD_WIDTH-1:0]     x_p1, y_p1;
  logic                       sof_p1, eof_p1;
  logic [COORD_WIDTH-1:0]     width, lines;
  logic [FRAME_CNT_WIDTH-1:0] frame_cnt;
  logic                       line_err, frame_err, done;

  // Stage p0: input sampling. fvalid resets high so SYNC only leaves once a
  // genuinely low fvalid has been sampled after reset.
  sync_edge_detect #(.RESET_VAL(1'b1)) u_fval (
    .clk   (clkmm),
    .reset (reset),
    .d     (iFvalid),
    .q     (fval_p0),
    .rise  (fval_rise),
    .fall  (fval_fall)
  );

  sync_edge_detect #(.RESET_VAL(1'b0)) u_lval (
    .clk   (clkmm),
    .reset (reset),
    .d     (iLvalid),
    .q     (lval_p0),
    .rise  (lval_rise),
    .fall  (lval_fall)
  );

  always_ff @(posedge clkmm) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= iValid;
    rgb_p0 <= iRgb;
  end

  // A frame may deliver its first pixel on the very cycle fvalid rises.
  assign start       = (state == IDLE) && fval_rise;
  assign active      = (state == FRAME) || start;
  assign x_cur       = (start || lval_rise) ? '0 : x;
  assign y_cur       = start ? '0 : y;
  assign sofp_cur    = start | sof_pending;
  assign pix         = active && vld_p0 && fval_p0 && lval_p0;
  assign close_line  = active && (lval_fall || fval_fall) && (x_cur != '0);
  assign frame_close = (state == FRAME) && fval_fall;
  assign y_closed    = close_line ? sat_inc(y_cur) : y_cur;
  assign cnt_next    = frame_cnt + FRAME_CNT_WIDTH'(1);
  assign limit       = (iNumberFrames != '0) && (cnt_next == iNumberFrames);

  always_ff @(posedge clkmm) begin
    if (reset) state <= SYNC;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SYNC:    if (!fval_p0) state_next = IDLE;
      IDLE:    if (fval_rise) state_next = FRAME;
      FRAME:   if (fval_fall) state_next = limit ? DONE : IDLE;
      DONE:    state_next = DONE;
      default: state_next = SYNC;
    endcase
  end

  // Stage p1: registered outputs and geometry bookkeeping.
  always_ff @(posedge clkmm) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      sof_pending <= 1'b0;
      pix_p1      <= '0;
      x_p1        <= '0;
      y_p1        <= '0;
      sof_p1      <= 1'b0;
      eof_p1      <= 1'b0;
      width       <= '0;
      lines       <= '0;
      frame_cnt   <= '0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
      done        <= 1'b0;
    end else begin
      pix_p1.valid <= 1'b0;
      sof_p1       <= 1'b0;
      eof_p1       <= 1'b0;
      if (active) begin
        y           <= y_closed;
        sof_pending <= sofp_cur & ~pix;
        if (close_line) x <= '0;
        else if (pix)   x <= sat_inc(x_cur);
        else            x <= x_cur;
        if (pix) begin
          pix_p1 <= split_rgb(1'b1, rgb_p0[23:0]);
          x_p1   <= x_cur;
          y_p1   <= y_cur;
          sof_p1 <= sofp_cur;
        end
        if (close_line) width <= x_cur;
        if (frame_close) begin
          lines     <= y_closed;
          eof_p1    <= 1'b1;
          frame_cnt <= cnt_next;
          done      <= limit;
        end
      end
      // A new mismatch outranks a simultaneous clear.
      line_err  <= (close_line && (x_cur != iImageWidth)) || (line_err && !iErrClear);
      frame_err <= (frame_close && (y_closed != iLvalLines)) || (frame_err && !iErrClear);
    end
  end

  assign oValid    = pix_p1.valid;
  assign oRed      = pix_p1.red;
  assign oGreen    = pix_p1.green;
  assign oBlue     = pix_p1.blue;
  assign oX        = x_p1;
  assign oY        = y_p1;
  assign oSof      = sof_p1;
  assign oEof      = eof_p1;
  assign oWidth    = width;
  assign oLines    = lines;
  assign oFrameCnt = frame_cnt;
  assign oLineErr  = line_err;
  assign oFrameErr = frame_err;
  assign oDone     = done;

endmodule

// File: doc/rgb_frame_receiver.md
# rgb_frame_receiver

Synthesizable receiver for the D5M-style raster stream (fvalid/lvalid/valid + 24-bit RGB) produced by the frame pattern generators. Recovers per-pixel x/y coordinates and sof/eof markers, checks line width and line count against runtime configuration, and counts frames up to a configured limit. Sits at the VFP ingress, ahead of filter stages and scoreboards that consume `rgb_channel`-shaped data.

## Interface
Parameters:
- `DATA_WIDTH`, 24, pixel width; red = [23:16], green = [15:8], blue = [7:0]
- `COORD_WIDTH`, 12, x/y and geometry counter width
- `FRAME_CNT_WIDTH`, 16, frame counter width

Ports:
- `clkmm` in 1: single clock; all logic on rising edge
- `reset` in 1: synchronous, active-high
- `iFvalid` in 1: frame valid
- `iLvalid` in 1: line valid
- `iValid` in 1: pixel valid; qualified by `iFvalid & iLvalid`
- `iRgb` in DATA_WIDTH: pixel data
- `iImageWidth` in COORD_WIDTH: expected pixels per line
- `iLvalLines` in COORD_WIDTH: expected lines per frame
- `iNumberFrames` in FRAME_CNT_WIDTH: frames to accept; 0 = unlimited
- `iErrClear` in 1: clears sticky error flags
- `oValid` out 1: registered pixel valid
- `oRed`, `oGreen`, `oBlue` out 8 each: registered pixel channels
- `oX`, `oY` out COORD_WIDTH: coordinates of current output pixel
- `oSof` out 1: high with first `oValid` of a frame
- `oEof` out 1: one-cycle pulse at frame close
- `oWidth`, `oLines` out COORD_WIDTH: measured geometry of last closed line/frame
- `oFrameCnt` out FRAME_CNT_WIDTH: completed frames
- `oLineErr`, `oFrameErr` out 1: sticky mismatch flags
- `oDone` out 1: frame limit reached

## Operation
- FSM: SYNC -> IDLE -> FRAME -> DONE.
- SYNC (after reset): wait for sampled `iFvalid == 0`, then IDLE; partial frames are never accepted.
- IDLE: rising `iFvalid` -> FRAME; x = 0, y = 0, sof_pending = 1.
- FRAME: each qualified pixel emits `oValid` with the current x, then x += 1 (saturates at 2^COORD_WIDTH-1). First qualified pixel asserts `oSof` and clears sof_pending.
- Line close (falling `iLvalid`, or falling `iFvalid` while a line is open), only if x > 0: `oWidth` <= x; `oLineErr` set if x != `iImageWidth`; y += 1 (saturating); x <= 0. Empty lvalid pulses are ignored.
- Frame close (falling `iFvalid`): close any open line first (same cycle); `oLines` <= final y; `oFrameErr` set if y != `iLvalLines`; `oEof` pulse; `oFrameCnt` += 1. Then IDLE, or DONE if `iNumberFrames != 0` and the new count == `iNumberFrames`.
- DONE: `oDone` = 1; inputs ignored and no `oValid`; only `reset` exits.
- `iValid` with `iLvalid` or `iFvalid` low: ignored. `iLvalid` with `iFvalid` low: ignored.
- `iErrClear` clears both flags. If a set and `iErrClear` occur in the same cycle, set wins.

## Timing
- All outputs registered. Pixel sampled at edge k appears on `oValid`/`oRgb`/`oX`/`oY` after edge k+1 (1-cycle latency).
- `oEof`, `oWidth`, `oLines`, `oFrameCnt`, and error flags update 1 cycle after the falling-edge sample that triggers them. `oEof` is high for exactly one cycle.
- Back-to-back frames: `iFvalid` high again on the cycle after it falls is accepted (IDLE entered same edge as `oEof`).
- Reset values: every output 0; FSM = SYNC.
- Reset mid-frame: outputs zeroed next edge; remainder of that frame discarded via SYNC.

## Structure
- Shared package additions: `rx_state_t` enum (SYNC/IDLE/FRAME/DONE) and packed `frame_stats` struct (width, lines, frame_cnt, line_err, frame_err). Reuse the existing `rgb_channel` / `cof_channel` field semantics for ports and config.
- One sub-module: `sync_edge_detect` (registered copy plus rise/fall pulses), instantiated for `iFvalid` and `iLvalid`.

## Test plan
- 2 frames, width 100, 5 lines, lvalid gap 10, `iNumberFrames` = 2 -> 1000 `oValid`; last pixel x = 99, y = 4; `oSof` ×2, `oEof` ×2; `oWidth` = 100, `oLines` = 5; `oFrameCnt` = 2; `oDone` = 1; errors 0.
- Line 3 short (99 px) -> `oLineErr` = 1 after that line closes and `oWidth` = 99; `iErrClear` -> 0.
- 4 lines with `iLvalLines` = 5 -> `oFrameErr` = 1 and `oLines` = 4 at `oEof`.
- Reset asserted mid-line of frame 1 while `iFvalid` is high -> no output until `iFvalid` falls and rises again; `oFrameCnt` restarts at 0.
- `iFvalid` falls while `iLvalid` is high (x = 40), `iImageWidth` = 100 -> line closed, `oWidth` = 40, `oLineErr` = 1, `oEof` pulses once.
- `iValid` toggling with `iLvalid` low, plus empty lvalid pulses -> no `oValid`, y unchanged.
